// File: rtl/button_event_arbiter_pkg.sv
// Shared types and helpers for the button event arbiter: debounce state
// encoding and the round-robin winner search.
package btn_arb_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        CHK_HIGH = 2'd1,
        ST_HIGH  = 2'd2,
        CHK_LOW  = 2'd3
    } deb_state_t;

    localparam int unsigned MAX_BTN = 16;

    // First set bit of pending at or above ptr, wrapping at n_btn.
    function automatic int unsigned rr_pick(input logic [MAX_BTN-1:0] pending,
                                            input int unsigned        ptr,
                                            input int unsigned        n_btn);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_BTN; k++) begin
            if (k < n_btn) begin
                idx = ptr + k;
                if (idx >= n_btn) idx = idx - n_btn;
                if (!found && pending[idx[3:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Valid/ready event channel carrying the index of the pressed button.
interface button_event_arbiter_if #(
    parameter int unsigned N_BTN = 4
);
    localparam int unsigned IDW = $clog2(N_BTN);

    logic           evt_valid;
    logic           evt_ready;
    logic [IDW-1:0] evt_id;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter_debounce_channel.sv
// One button channel: two-flop synchroniser, counter-based debounce FSM and
// a single-cycle pulse on the cycle a debounced press is committed.
module debounce_channel
    import btn_arb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_async,
    output logic btn_level,
    output logic rise
);
    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    deb_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          level_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= ST_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
        end else begin
            sync1     <= btn_async;
            sync2     <= sync1;
            state     <= state_nx;
            cnt       <= cnt_nx;
            btn_level <= level_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = btn_level;
        rise     = 1'b0;
        case (state)
            ST_LOW: if (sync2) begin
                state_nx = CHK_HIGH;
                cnt_nx   = '0;
            end
            CHK_HIGH: begin
                if (!sync2) begin
                    state_nx = ST_LOW;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_HIGH;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    rise     = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_HIGH: if (!sync2) begin
                state_nx = CHK_LOW;
                cnt_nx   = '0;
            end
            CHK_LOW: begin
                if (sync2) begin
                    state_nx = ST_HIGH;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_LOW;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = ST_LOW;
        endcase
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N push buttons and serialises their presses onto one valid/ready
// event channel with a round-robin scheduler.
module button_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_BTN-1:0]              btn_async,
    output logic [N_BTN-1:0]              btn_level,
    button_event_arbiter_if.master        evt,
    output logic [N_BTN-1:0]              evt_pending,
    output logic                          overflow
);
    localparam int unsigned IDW = $clog2(N_BTN);

    logic [N_BTN-1:0]   rise;
    logic [N_BTN-1:0]   clr;
    logic [MAX_BTN-1:0] pend_ext;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     winner;
    logic               hs, load;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_async (btn_async[i]),
            .btn_level (btn_level[i]),
            .rise      (rise[i])
        );
    end

    always_comb begin
        pend_ext              = '0;
        pend_ext[N_BTN-1:0]   = evt_pending;
        winner                = IDW'(rr_pick(pend_ext, int'(ptr), N_BTN));
        hs                    = evt.evt_valid & evt.evt_ready;
        load                  = (!evt.evt_valid || hs) && (|evt_pending);
        clr                   = '0;
        if (load) clr[winner] = 1'b1;
    end

    // A rise on the bit being loaded re-sets it (set wins); a rise onto a bit
    // that stays pending is dropped and reported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_pending   <= '0;
            overflow      <= 1'b0;
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
            ptr           <= '0;
        end else begin
            evt_pending <= (evt_pending & ~clr) | rise;
            overflow    <= |(rise & evt_pending & ~clr);
            if (load) begin
                evt.evt_valid <= 1'b1;
                evt.evt_id    <= winner;
                ptr           <= (winner == IDW'(N_BTN - 1)) ? '0 : winner + 1'b1;
            end else if (hs) begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: a run-length debounce model and
// a round-robin pending model predict events; a monitor checks the DUT.
module tb_button_event_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_async;
    logic [N-1:0] btn_level;
    logic [N-1:0] evt_pending;
    logic         overflow;

    button_event_arbiter_if #(.N_BTN(N)) evt ();

    button_event_arbiter #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_async   (btn_async),
        .btn_level   (btn_level),
        .evt         (evt.master),
        .evt_pending (evt_pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_events = 0;
    int dut_ovf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips once the synchronised input has differed
    // from it for D+1 consecutive samples; presses queue in a pending set that
    // is served round-robin from the slot after the last one served.
    int unsigned  run [N];
    logic [N-1:0] d1 = '0, d2 = '0, lvl_m = '0, pend_m = '0;
    logic [N-1:0] m_rise, m_clr;
    logic         valid_m = 1'b0, ovf_m = 1'b0, m_hs, m_found;
    int unsigned  ptr_m = 0, m_w = 0;
    int           exp_q [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) run[i] = 0;
            d1 = '0; d2 = '0; lvl_m = '0; pend_m = '0;
            valid_m = 1'b0; ovf_m = 1'b0; ptr_m = 0;
            exp_q.delete();
        end else begin
            m_rise = '0;
            for (int i = 0; i < N; i++) begin
                if (d2[i] != lvl_m[i]) run[i] = run[i] + 1;
                else run[i] = 0;
                if (run[i] == D + 1) begin
                    lvl_m[i] = d2[i];
                    run[i] = 0;
                    if (d2[i]) m_rise[i] = 1'b1;
                end
            end
            d2 = d1;
            d1 = btn_async;
            m_hs  = valid_m && evt.evt_ready;
            m_clr = '0;
            if ((!valid_m || m_hs) && pend_m != '0) begin
                m_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!m_found && pend_m[(ptr_m + k) % N]) begin
                        m_w = (ptr_m + k) % N;
                        m_found = 1'b1;
                    end
                end
                exp_q.push_back(m_w);
                valid_m = 1'b1;
                m_clr[m_w] = 1'b1;
                ptr_m = (m_w + 1) % N;
            end else if (m_hs) begin
                valid_m = 1'b0;
            end
            ovf_m  = |(m_rise & pend_m & ~m_clr);
            pend_m = (pend_m & ~m_clr) | m_rise;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("btn_level", btn_level, lvl_m);
            check("evt_pending", evt_pending, pend_m);
            check("overflow", overflow, ovf_m);
            check("evt_valid", evt.evt_valid, valid_m);
            if (overflow === 1'b1) dut_ovf++;
            if (evt.evt_valid === 1'b1 && evt.evt_ready === 1'b1) begin
                n_events++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evt_unexpected: got id %0d expected no event at %0t", evt.evt_id, $time);
                end else begin
                    check("evt_id", evt.evt_id, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int ev0, ov0;

    initial begin
        reset = 1'b1;
        btn_async = '0;
        evt.evt_ready = 1'b1;
        tick(3);
        check("rst_level", btn_level, 0);
        check("rst_pending", evt_pending, 0);
        check("rst_valid", evt.evt_valid, 0);
        check("rst_id", evt.evt_id, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        tick(3);

        // clean press on button 2
        ev0 = n_events;
        btn_async[2] = 1'b1; tick(15);
        btn_async[2] = 1'b0; tick(15);
        check("clean_events", n_events - ev0, 1);

        // bounce on button 1: short pulse must be filtered
        ev0 = n_events;
        btn_async[1] = 1'b1; tick(3);
        btn_async[1] = 1'b0; tick(1);
        btn_async[1] = 1'b1; tick(15);
        btn_async[1] = 1'b0; tick(15);
        check("bounce_events", n_events - ev0, 1);

        // simultaneous commits on 0,1,3 then a lone press on 0
        ev0 = n_events;
        btn_async = 4'b1011; tick(15);
        btn_async = '0;      tick(12);
        btn_async[0] = 1'b1; tick(12);
        btn_async[0] = 1'b0; tick(12);
        check("simul_events", n_events - ev0, 4);

        // stall with three presses on button 3
        ev0 = n_events;
        ov0 = dut_ovf;
        evt.evt_ready = 1'b0;
        repeat (3) begin
            btn_async[3] = 1'b1; tick(8);
            btn_async[3] = 1'b0; tick(8);
        end
        check("stall_id", evt.evt_id, 3);
        check("stall_valid", evt.evt_valid, 1);
        check("stall_ovf", dut_ovf - ov0, 1);
        evt.evt_ready = 1'b1;
        tick(10);
        check("stall_events", n_events - ev0, 2);

        // reset with an event in flight and pending 1010
        evt.evt_ready = 1'b0;
        btn_async[0] = 1'b1; tick(10);
        btn_async = 4'b1011; tick(10);
        btn_async = '0;      tick(10);
        check("pre_rst_pending", evt_pending, 4'b1010);
        check("pre_rst_valid", evt.evt_valid, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", evt.evt_valid, 0);
        check("async_rst_pending", evt_pending, 0);
        check("async_rst_level", btn_level, 0);
        check("async_rst_id", evt.evt_id, 0);
        check("async_rst_ovf", overflow, 0);
        tick(1);
        reset = 1'b0;
        evt.evt_ready = 1'b1;
        ev0 = n_events;
        tick(30);
        check("post_rst_events", n_events - ev0, 0);

        // five presses on button 0
        ev0 = n_events;
        ov0 = dut_ovf;
        repeat (5) begin
            btn_async[0] = 1'b1; tick(10);
            btn_async[0] = 1'b0; tick(10);
        end
        check("repeat_events", n_events - ev0, 5);
        check("repeat_ovf", dut_ovf - ov0, 0);

        // randomised buttons and back-pressure
        repeat (600) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) btn_async[i] = ~btn_async[i];
            evt.evt_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        btn_async = '0;
        evt.evt_ready = 1'b1;
        tick(40);
        check("drain_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
